// File: rtl/add_share_arbiter_pkg.sv
// Shared types and default sizes for the add-share arbiter.
package add_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 4;

endpackage

// File: rtl/add_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IDW-1:0]  index,
   output logic            any
);

   int             pos;
   logic [IDW-1:0] pos_i;
   logic           found;

   always_comb begin
      onehot = '0;
      index  = '0;
      any    = |req;
      found  = 1'b0;
      pos    = 0;
      pos_i  = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         pos_i = IDW'(pos);
         if (!found && req[pos_i]) begin
            found         = 1'b1;
            onehot[pos_i] = 1'b1;
            index         = pos_i;
         end
      end
   end

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one W-bit adder between NREQ clients.
// Build option ADD_SHARE_SAT_EN: saturate the sum to W bits instead of returning the carry.
module add_share_arbiter
   import add_share_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] op_a,
   input  logic [NREQ*W-1:0] op_b,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              done,
   output logic [IDW-1:0]    done_id,
   output logic [W:0]        sum
);

   function automatic logic [W:0] add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef ADD_SHARE_SAT_EN
      return s[W] ? {1'b0, {W{1'b1}}} : s;
`else
      return s;
`endif
   endfunction

   state_t          state, state_nxt;
   logic [NREQ-1:0] pick_oh;
   logic [IDW-1:0]  pick_idx;
   logic            pick_any;
   logic [IDW-1:0]  ptr;
   logic [W-1:0]    sel_a, sel_b;

   logic [NREQ-1:0] gnt_p0;
   logic [W-1:0]    a_p0, b_p0;
   logic [IDW-1:0]  id_p0;
   logic [W:0]      sum_p1;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .index  (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_a = sel_a | (op_a[i*W +: W] & {W{pick_oh[i]}});
         sel_b = sel_b | (op_b[i*W +: W] & {W{pick_oh[i]}});
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = CALC;
         CALC:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Stage p0: grant and operand capture; stage p1: registered sum
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_p0 <= '0;
         a_p0   <= '0;
         b_p0   <= '0;
         id_p0  <= '0;
         ptr    <= '0;
         sum_p1 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_p0 <= pick_oh;
                  a_p0   <= sel_a;
                  b_p0   <= sel_b;
                  id_p0  <= pick_idx;
                  ptr    <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
               end
            end
            CALC:    sum_p1 <= add_sat(a_p0, b_p0);
            DONE:    gnt_p0 <= '0;
            default: ;
         endcase
      end
   end

   assign gnt     = gnt_p0;
   assign busy    = (state == CALC) || (state == DONE);
   assign done    = (state == DONE);
   assign done_id = id_p0;
   assign sum     = sum_p1;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: vector table plus contention, drop-out and reset sequences.
module tb_add_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] op_a, op_b;
   logic [NREQ-1:0]   gnt;
   logic              busy, done;
   logic [IDW-1:0]    done_id;
   logic [W:0]        sum;

   int n_tests = 0;
   int n_fail  = 0;

   add_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .op_a    (op_a),
      .op_b    (op_b),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .sum     (sum)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cl;
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] exp_full;
      logic [4:0] exp_sat;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
      op_a[c*W +: W] = a;
      op_b[c*W +: W] = b;
   endtask

   function automatic logic [4:0] pick_exp(input vec_t v);
`ifdef ADD_SHARE_SAT_EN
      return v.exp_sat;
`else
      return v.exp_full;
`endif
   endfunction

   // Single client, request dropped in its done cycle.
   task automatic run_single(input string tag, input int cl, input logic [3:0] a,
                             input logic [3:0] b, input logic [4:0] exp);
      logic [3:0] oh;
      oh = 4'(1 << cl);
      set_op(cl, a, b);
      req = oh;
      tick();
      check({tag, " e0 gnt/busy/done"}, {gnt, busy, done}, {oh, 1'b1, 1'b0});
      tick();
      check({tag, " e1 done"}, {gnt, busy, done, done_id, sum}, {oh, 1'b1, 1'b1, 2'(cl), exp});
      req = '0;
      tick();
      check({tag, " e2 idle"}, {gnt, busy, done, sum}, {4'b0, 1'b0, 1'b0, exp});
   endtask

   initial begin
      vecs[0] = '{cl: 0, a: 4'd2,  b: 4'd5,  exp_full: 5'd7,  exp_sat: 5'd7};
      vecs[1] = '{cl: 2, a: 4'd15, b: 4'd15, exp_full: 5'd30, exp_sat: 5'd15};
      vecs[2] = '{cl: 1, a: 4'd4,  b: 4'd7,  exp_full: 5'd11, exp_sat: 5'd11};
      vecs[3] = '{cl: 3, a: 4'd0,  b: 4'd0,  exp_full: 5'd0,  exp_sat: 5'd0};
      vecs[4] = '{cl: 1, a: 4'd9,  b: 4'd8,  exp_full: 5'd17, exp_sat: 5'd15};
      vecs[5] = '{cl: 0, a: 4'd15, b: 4'd1,  exp_full: 5'd16, exp_sat: 5'd15};

      rst_n = 1'b0;
      req   = '0;
      op_a  = '0;
      op_b  = '0;
      tick();
      tick();
      check("reset outputs", {gnt, busy, done, done_id, sum}, 13'd0);
      rst_n = 1'b1;
      tick();
      tick();
      check("idle no req", {gnt, busy, done}, 6'd0);

      for (int i = 0; i < 6; i++)
         run_single($sformatf("vec%0d", i), vecs[i].cl, vecs[i].a, vecs[i].b, pick_exp(vecs[i]));

      // Contention from ptr=0: order 0,1,2,3 then 0 again.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < NREQ; c++) set_op(c, 4'(c + 1), 4'(c + 2));
      req = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         int c;
         c = r % NREQ;
         tick();
         check($sformatf("rr%0d gnt", r), {gnt, busy}, {4'(1 << c), 1'b1});
         tick();
         check($sformatf("rr%0d done", r), {done, done_id, sum}, {1'b1, 2'(c), 5'(2 * c + 3)});
         req[c] = 1'b0;
         if (r == 3) req = 4'b1111;
         if (r == 4) req = '0;
         tick();
         check($sformatf("rr%0d release", r), {gnt, done}, 5'd0);
      end

      // Operand change after grant is ignored.
      set_op(1, 4'd6, 4'd1);
      req = 4'b0010;
      tick();
      set_op(1, 4'd5, 4'd1);
      tick();
      check("stable sum", {done, done_id, sum}, {1'b1, 2'd1, 5'd7});
      req = '0;
      tick();

      // Client drops req during CALC and is still answered.
      set_op(2, 4'd3, 4'd3);
      req = 4'b0100;
      tick();
      req = '0;
      tick();
      check("dropout done", {done, done_id, sum}, {1'b1, 2'd2, 5'd6});
      tick();
      check("dropout idle", {gnt, busy, done}, 6'd0);

      // Reset in CALC: no done, and the pointer goes back to 0.
      set_op(2, 4'd1, 4'd1);
      req = 4'b0100;
      tick();
      check("pre-abort gnt", gnt, 4'b0100);
      rst_n = 1'b0;
      req   = '0;
      tick();
      check("abort outputs", {gnt, busy, done, done_id, sum}, 13'd0);
      rst_n = 1'b1;
      tick();
      check("abort no done", {gnt, busy, done}, 6'd0);
      set_op(0, 4'd1, 4'd2);
      set_op(3, 4'd7, 4'd7);
      req = 4'b1001;
      tick();
      check("post-reset ptr", gnt, 4'b0001);
      tick();
      check("post-reset done0", {done, done_id, sum}, {1'b1, 2'd0, 5'd3});
      req = 4'b1000;
      tick();
      tick();
      check("wrap to 3 gnt", gnt, 4'b1000);
      tick();
      check("wrap to 3 done", {done, done_id, sum}, {1'b1, 2'd3, 5'd14});
      req = '0;
      tick();
      check("final idle", {gnt, busy, done}, 6'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
